// File: rtl/cpu_control_multi_pkg.sv
// Shared definitions for the multi-cycle CPU controller.
//   - FSM state encoding (IF=0 .. WB=4)
//   - MIPS opcode / function field constants for the supported subset
//   - ALU function codes, ALU-B and next-PC select codes
//   - one-hot instruction flag struct produced by cpu_decode
package cpu_control_multi_pkg;

    typedef enum logic [2:0] {
        StIf  = 3'd0,
        StId  = 3'd1,
        StExe = 3'd2,
        StMem = 3'd3,
        StWb  = 3'd4
    } state_e;

    // Opcode field values
    localparam logic [5:0] OpRtype = 6'b000000;
    localparam logic [5:0] OpJ     = 6'b000010;
    localparam logic [5:0] OpJal   = 6'b000011;
    localparam logic [5:0] OpBeq   = 6'b000100;
    localparam logic [5:0] OpBne   = 6'b000101;
    localparam logic [5:0] OpAddi  = 6'b001000;
    localparam logic [5:0] OpAndi  = 6'b001100;
    localparam logic [5:0] OpOri   = 6'b001101;
    localparam logic [5:0] OpXori  = 6'b001110;
    localparam logic [5:0] OpLui   = 6'b001111;
    localparam logic [5:0] OpLw    = 6'b100011;
    localparam logic [5:0] OpSw    = 6'b101011;

    // Function field values (R-type)
    localparam logic [5:0] FunSll = 6'b000000;
    localparam logic [5:0] FunSrl = 6'b000010;
    localparam logic [5:0] FunSra = 6'b000011;
    localparam logic [5:0] FunJr  = 6'b001000;
    localparam logic [5:0] FunAdd = 6'b100000;
    localparam logic [5:0] FunSub = 6'b100010;
    localparam logic [5:0] FunAnd = 6'b100100;
    localparam logic [5:0] FunOr  = 6'b100101;
    localparam logic [5:0] FunXor = 6'b100110;

    // ALU function codes
    localparam logic [3:0] AlucAdd = 4'b0000;
    localparam logic [3:0] AlucSub = 4'b0100;
    localparam logic [3:0] AlucAnd = 4'b0001;
    localparam logic [3:0] AlucOr  = 4'b0101;
    localparam logic [3:0] AlucXor = 4'b0010;
    localparam logic [3:0] AlucLui = 4'b0110;
    localparam logic [3:0] AlucSll = 4'b0011;
    localparam logic [3:0] AlucSrl = 4'b0111;
    localparam logic [3:0] AlucSra = 4'b1111;

    // ALU B operand select
    localparam logic [1:0] SrcbRegB  = 2'b00;
    localparam logic [1:0] SrcbFour  = 2'b01;
    localparam logic [1:0] SrcbImm   = 2'b10;
    localparam logic [1:0] SrcbImmSh = 2'b11;

    // Next-PC select
    localparam logic [1:0] PcAlu    = 2'b00;
    localparam logic [1:0] PcAluReg = 2'b01;
    localparam logic [1:0] PcRegA   = 2'b10;
    localparam logic [1:0] PcJump   = 2'b11;

    typedef struct packed {
        logic is_add;
        logic is_sub;
        logic is_and;
        logic is_or;
        logic is_xor;
        logic is_sll;
        logic is_srl;
        logic is_sra;
        logic is_jr;
        logic is_addi;
        logic is_andi;
        logic is_ori;
        logic is_xori;
        logic is_lui;
        logic is_lw;
        logic is_sw;
        logic is_beq;
        logic is_bne;
        logic is_j;
        logic is_jal;
    } instr_t;

    // ALU function for the R-type and I-type ALU instructions executed in EXE.
    function automatic logic [3:0] alu_code(input instr_t ins);
        logic [3:0] code;
        code = AlucAdd;
        if (ins.is_sub)                    code = AlucSub;
        else if (ins.is_and || ins.is_andi) code = AlucAnd;
        else if (ins.is_or  || ins.is_ori)  code = AlucOr;
        else if (ins.is_xor || ins.is_xori) code = AlucXor;
        else if (ins.is_lui)               code = AlucLui;
        else if (ins.is_sll)               code = AlucSll;
        else if (ins.is_srl)               code = AlucSrl;
        else if (ins.is_sra)               code = AlucSra;
        return code;
    endfunction

endpackage

// File: rtl/cpu_decode.sv
// Combinational instruction decoder.
//   i_op    : opcode field
//   i_fun   : function field (only meaningful when i_op is R-type)
//   o_instr : one-hot instruction flags; all zero for an undecoded instruction
module cpu_decode
    import cpu_control_multi_pkg::*;
(
    input  logic [5:0] i_op,
    input  logic [5:0] i_fun,
    output instr_t     o_instr
);

    logic w_rtype;

    always_comb begin
        w_rtype         = (i_op == OpRtype);
        o_instr         = '0;
        o_instr.is_add  = w_rtype && (i_fun == FunAdd);
        o_instr.is_sub  = w_rtype && (i_fun == FunSub);
        o_instr.is_and  = w_rtype && (i_fun == FunAnd);
        o_instr.is_or   = w_rtype && (i_fun == FunOr);
        o_instr.is_xor  = w_rtype && (i_fun == FunXor);
        o_instr.is_sll  = w_rtype && (i_fun == FunSll);
        o_instr.is_srl  = w_rtype && (i_fun == FunSrl);
        o_instr.is_sra  = w_rtype && (i_fun == FunSra);
        o_instr.is_jr   = w_rtype && (i_fun == FunJr);
        o_instr.is_addi = (i_op == OpAddi);
        o_instr.is_andi = (i_op == OpAndi);
        o_instr.is_ori  = (i_op == OpOri);
        o_instr.is_xori = (i_op == OpXori);
        o_instr.is_lui  = (i_op == OpLui);
        o_instr.is_lw   = (i_op == OpLw);
        o_instr.is_sw   = (i_op == OpSw);
        o_instr.is_beq  = (i_op == OpBeq);
        o_instr.is_bne  = (i_op == OpBne);
        o_instr.is_j    = (i_op == OpJ);
        o_instr.is_jal  = (i_op == OpJal);
    end

endmodule

// File: rtl/cpu_control_multi.sv
// Multi-cycle MIPS-subset control unit (IF, ID, EXE, MEM, WB).
//   clk, rst        : clock, synchronous active-high reset
//   op, fun, z      : instruction opcode/function fields, ALU zero flag
//   mem_ready       : memory finishes the current access this cycle
//   wpc, wir, wmem, wreg          : write enables (forced low during rst)
//   iord, regrt, m2reg, jal       : datapath steering
//   aluc, shift, alusrca, alusrcb, sext : ALU control
//   pcsource        : next-PC select
//   state           : current FSM state
//   illegal         : pulses in ID for an undecoded instruction
// All outputs are combinational from state and inputs; only the state is registered.
module cpu_control_multi
    import cpu_control_multi_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [5:0] op,
    input  logic [5:0] fun,
    input  logic       z,
    input  logic       mem_ready,
    output logic       wpc,
    output logic       wir,
    output logic       wmem,
    output logic       iord,
    output logic       wreg,
    output logic       regrt,
    output logic       m2reg,
    output logic       jal,
    output logic [3:0] aluc,
    output logic       shift,
    output logic       alusrca,
    output logic [1:0] alusrcb,
    output logic       sext,
    output logic [1:0] pcsource,
    output logic [2:0] state,
    output logic       illegal
);

    state_e r_state;
    state_e w_next;
    instr_t w_ins;
    logic   w_shift_op;
    logic   w_ralu;
    logic   w_ialu;
    logic   w_legal;

    cpu_decode u_decode (
        .i_op    (op),
        .i_fun   (fun),
        .o_instr (w_ins)
    );

    assign w_shift_op = w_ins.is_sll | w_ins.is_srl | w_ins.is_sra;
    assign w_ralu     = w_ins.is_add | w_ins.is_sub | w_ins.is_and | w_ins.is_or |
                        w_ins.is_xor | w_shift_op;
    assign w_ialu     = w_ins.is_addi | w_ins.is_andi | w_ins.is_ori | w_ins.is_xori |
                        w_ins.is_lui;
    assign w_legal    = |w_ins;
    assign state      = r_state;

    always_ff @(posedge clk) begin
        if (rst) r_state <= StIf;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next   = r_state;
        wpc      = 1'b0;
        wir      = 1'b0;
        wmem     = 1'b0;
        iord     = 1'b0;
        wreg     = 1'b0;
        regrt    = 1'b0;
        m2reg    = 1'b0;
        jal      = 1'b0;
        aluc     = AlucAdd;
        shift    = 1'b0;
        alusrca  = 1'b0;
        alusrcb  = SrcbRegB;
        sext     = 1'b0;
        pcsource = PcAlu;
        illegal  = 1'b0;

        case (r_state)
            StIf: begin
                // Fetch: PC+4 computed in parallel with the instruction read.
                alusrcb = SrcbFour;
                wpc     = mem_ready;
                wir     = mem_ready;
                w_next  = mem_ready ? StId : StIf;
            end
            StId: begin
                // Branch target is computed speculatively for every instruction.
                alusrcb = SrcbImmSh;
                sext    = 1'b1;
                if (w_ins.is_j || w_ins.is_jal) begin
                    wpc      = 1'b1;
                    pcsource = PcJump;
                    wreg     = w_ins.is_jal;
                    jal      = w_ins.is_jal;
                    w_next   = StIf;
                end else if (w_ins.is_jr) begin
                    wpc      = 1'b1;
                    pcsource = PcRegA;
                    w_next   = StIf;
                end else if (!w_legal) begin
                    illegal = 1'b1;
                    w_next  = StIf;
                end else begin
                    w_next = StExe;
                end
            end
            StExe: begin
                alusrca = 1'b1;
                if (w_ralu) begin
                    shift  = w_shift_op;
                    aluc   = alu_code(w_ins);
                    w_next = StWb;
                end else if (w_ialu) begin
                    alusrcb = SrcbImm;
                    sext    = w_ins.is_addi;
                    aluc    = alu_code(w_ins);
                    w_next  = StWb;
                end else if (w_ins.is_lw || w_ins.is_sw) begin
                    alusrcb = SrcbImm;
                    sext    = 1'b1;
                    w_next  = StMem;
                end else if (w_ins.is_beq || w_ins.is_bne) begin
                    aluc     = AlucSub;
                    pcsource = PcAluReg;
                    wpc      = w_ins.is_beq ? z : ~z;
                    w_next   = StIf;
                end else begin
                    w_next = StIf;
                end
            end
            StMem: begin
                iord = 1'b1;
                if (w_ins.is_sw) begin
                    wmem   = 1'b1;
                    w_next = mem_ready ? StIf : StMem;
                end else begin
                    w_next = mem_ready ? StWb : StMem;
                end
            end
            StWb: begin
                wreg   = 1'b1;
                regrt  = w_ialu | w_ins.is_lw;
                m2reg  = w_ins.is_lw;
                w_next = StIf;
            end
            default: w_next = StIf;
        endcase

        // Reset must never let a stale state commit anything.
        if (rst) begin
            wpc     = 1'b0;
            wir     = 1'b0;
            wmem    = 1'b0;
            wreg    = 1'b0;
            illegal = 1'b0;
        end
    end

endmodule

// File: tb/tb_cpu_control_multi.sv
module tb_cpu_control_multi;

    logic       clk;
    logic       rst;
    logic [5:0] op;
    logic [5:0] fun;
    logic       z;
    logic       mem_ready;
    logic       wpc, wir, wmem, iord, wreg, regrt, m2reg, jal;
    logic [3:0] aluc;
    logic       shift, alusrca, sext, illegal;
    logic [1:0] alusrcb, pcsource;
    logic [2:0] state;

    int checks = 0;
    int errors = 0;

    cpu_control_multi dut (
        .clk       (clk),
        .rst       (rst),
        .op        (op),
        .fun       (fun),
        .z         (z),
        .mem_ready (mem_ready),
        .wpc       (wpc),
        .wir       (wir),
        .wmem      (wmem),
        .iord      (iord),
        .wreg      (wreg),
        .regrt     (regrt),
        .m2reg     (m2reg),
        .jal       (jal),
        .aluc      (aluc),
        .shift     (shift),
        .alusrca   (alusrca),
        .alusrcb   (alusrcb),
        .sext      (sext),
        .pcsource  (pcsource),
        .state     (state),
        .illegal   (illegal)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one clock and settle just after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int n;
        int waits;

        rst = 1'b1; op = 6'b000000; fun = 6'b000000; z = 1'b0; mem_ready = 1'b1;
        step();
        chk("rst_state", 32'(state), 0);
        chk("rst_wpc_forced", 32'(wpc), 0);
        chk("rst_wir_forced", 32'(wir), 0);

        // add: IF, ID, EXE, WB
        rst = 1'b0; fun = 6'b100000; #1;
        chk("if_state", 32'(state), 0);
        chk("if_wpc", 32'(wpc), 1);
        chk("if_wir", 32'(wir), 1);
        chk("if_alusrcb", 32'(alusrcb), 'b01);
        chk("if_iord", 32'(iord), 0);
        step();
        chk("add_id_state", 32'(state), 1);
        chk("add_id_alusrcb", 32'(alusrcb), 'b11);
        chk("add_id_sext", 32'(sext), 1);
        chk("add_id_wreg", 32'(wreg), 0);
        mem_ready = 1'b0;  // ignored outside IF/MEM
        step();
        chk("add_exe_state", 32'(state), 2);
        chk("add_exe_alusrca", 32'(alusrca), 1);
        chk("add_exe_alusrcb", 32'(alusrcb), 'b00);
        chk("add_exe_aluc", 32'(aluc), 'b0000);
        chk("add_exe_wreg", 32'(wreg), 0);
        step();
        chk("add_wb_state", 32'(state), 4);
        chk("add_wb_wreg", 32'(wreg), 1);
        chk("add_wb_regrt", 32'(regrt), 0);
        step();
        chk("add_back_if", 32'(state), 0);
        chk("if_wait_wpc", 32'(wpc), 0);
        step();
        chk("if_wait_hold", 32'(state), 0);
        mem_ready = 1'b1;

        // sra shift path
        fun = 6'b000011;
        step(); step();
        chk("sra_exe_aluc", 32'(aluc), 'b1111);
        chk("sra_exe_shift", 32'(shift), 1);
        step(); step();

        // lw with two MEM wait cycles
        op = 6'b100011; fun = 6'b000000;
        n = 0; waits = 0;
        for (int i = 0; i < 20; i++) begin
            if (state == 3 && waits < 2) begin
                mem_ready = 1'b0;
                waits++;
            end else begin
                mem_ready = 1'b1;
            end
            #1;
            if (state == 3) begin
                chk("lw_mem_iord", 32'(iord), 1);
                chk("lw_mem_wmem", 32'(wmem), 0);
            end
            if (state == 4) begin
                chk("lw_wb_m2reg", 32'(m2reg), 1);
                chk("lw_wb_wreg", 32'(wreg), 1);
                chk("lw_wb_regrt", 32'(regrt), 1);
            end
            step();
            n++;
            if (state == 0) break;
        end
        chk("lw_cycles", n, 7);
        mem_ready = 1'b1;

        // beq taken / not taken
        op = 6'b000100; z = 1'b1;
        step(); step();
        chk("beq_exe_state", 32'(state), 2);
        chk("beq_z1_wpc", 32'(wpc), 1);
        chk("beq_pcsource", 32'(pcsource), 'b01);
        chk("beq_aluc", 32'(aluc), 'b0100);
        z = 1'b0; #1;
        chk("beq_z0_wpc", 32'(wpc), 0);
        step();
        chk("beq_back_if", 32'(state), 0);

        // bne, z=0 -> taken
        op = 6'b000101;
        step(); step();
        chk("bne_z0_wpc", 32'(wpc), 1);
        step();

        // jal
        op = 6'b000011;
        step();
        chk("jal_id_state", 32'(state), 1);
        chk("jal_wpc", 32'(wpc), 1);
        chk("jal_wreg", 32'(wreg), 1);
        chk("jal_jal", 32'(jal), 1);
        chk("jal_pcsource", 32'(pcsource), 'b11);
        step();
        chk("jal_back_if", 32'(state), 0);

        // jr
        op = 6'b000000; fun = 6'b001000;
        step();
        chk("jr_wpc", 32'(wpc), 1);
        chk("jr_pcsource", 32'(pcsource), 'b10);
        chk("jr_wreg", 32'(wreg), 0);
        step();
        chk("jr_back_if", 32'(state), 0);

        // undecoded opcode
        op = 6'b111111;
        step();
        chk("ill_pulse", 32'(illegal), 1);
        chk("ill_wpc", 32'(wpc), 0);
        chk("ill_wreg", 32'(wreg), 0);
        chk("ill_wir", 32'(wir), 0);
        step();
        chk("ill_back_if", 32'(state), 0);
        chk("ill_cleared", 32'(illegal), 0);

        // ori: zero-extended immediate, rt destination
        op = 6'b001101;
        step(); step();
        chk("ori_alusrcb", 32'(alusrcb), 'b10);
        chk("ori_sext", 32'(sext), 0);
        chk("ori_aluc", 32'(aluc), 'b0101);
        step();
        chk("ori_wb_regrt", 32'(regrt), 1);
        chk("ori_wb_m2reg", 32'(m2reg), 0);
        step();

        // addi: sign-extended
        op = 6'b001000;
        step(); step();
        chk("addi_sext", 32'(sext), 1);
        chk("addi_aluc", 32'(aluc), 'b0000);
        step(); step();

        // sw stalled in MEM, then reset
        op = 6'b101011;
        step(); step();
        mem_ready = 1'b0;
        step();
        chk("sw_mem_state", 32'(state), 3);
        chk("sw_mem_wmem", 32'(wmem), 1);
        step();
        chk("sw_mem_hold", 32'(state), 3);
        rst = 1'b1; #1;
        chk("sw_rst_wmem", 32'(wmem), 0);
        step();
        chk("sw_rst_state", 32'(state), 0);
        rst = 1'b0; mem_ready = 1'b1; #1;
        chk("post_rst_wpc", 32'(wpc), 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/cpu_control_multi.md
CPU_CONTROL_MULTI -- requirements
Module: cpu_control_multi

Interface
REQ-001 The block SHALL have one clock and one reset; reset is synchronous and active-high.
REQ-002 clk  input  1  rising-edge clock.
REQ-003 rst  input  1  synchronous active-high reset.
REQ-004 op  input  6  opcode field of the instruction register; fun  input  6  function field.
REQ-005 z  input  1  ALU zero flag; mem_ready  input  1  memory completes the current access this cycle.
REQ-006 wpc  output  1  PC write enable; wir  output  1  instruction register write enable.
REQ-007 wmem  output  1  memory write enable; iord  output  1  memory address source (0 = PC, 1 = ALU register).
REQ-008 wreg  output  1  register-file write enable; regrt  output  1  destination is rt; m2reg  output  1  write-back from memory; jal  output  1  write PC to $31.
REQ-009 aluc  output  4  ALU function; shift  output  1  ALU A = shamt; alusrca  output  1  (0 = PC, 1 = register A).
REQ-010 alusrcb  output  2  ALU B: 00 = reg B, 01 = constant 4, 10 = extended imm, 11 = extended imm<<2; sext  output  1  sign-extend imm.
REQ-011 pcsource  output  2  next PC: 00 = ALU, 01 = ALU register (branch target), 10 = reg A (jr), 11 = jump address.
REQ-012 state  output  3  current FSM state; illegal  output  1  one-cycle pulse on undecoded instruction.

Function
REQ-013 Supported set SHALL be add, sub, and, or, xor, sll, srl, sra, jr, addi, andi, ori, xori, lw, sw, beq, bne, lui, j, jal, using standard MIPS op/fun encodings.
REQ-014 aluc codes SHALL be: add 0000, sub 0100, and 0001, or 0101, xor 0010, lui 0110, sll 0011, srl 0111, sra 1111.
REQ-015 States SHALL be IF=0, ID=1, EXE=2, MEM=3, WB=4; outputs are combinational from state, op, fun, z and mem_ready; all unlisted outputs are 0.
REQ-016 IF: iord=0, alusrca=0, alusrcb=01, aluc=add, pcsource=00; wpc=wir=mem_ready; remain in IF until mem_ready=1, then go to ID.
REQ-017 ID: alusrca=0, alusrcb=11, sext=1, aluc=add (branch target latched into ALU register).
REQ-018 ID, j: wpc=1, pcsource=11 -> IF. jal: also wreg=1, jal=1 -> IF. jr: wpc=1, pcsource=10 -> IF.
REQ-019 ID, undecoded op/fun: illegal=1, no write enables -> IF; all other instructions -> EXE.
REQ-020 EXE, R-type ALU ops: alusrca=1 (shift=1 for sll/srl/sra), alusrcb=00 -> WB.
REQ-021 EXE, I-type ALU ops and lui: alusrca=1, alusrcb=10, sext=1 only for addi -> WB.
REQ-022 EXE, lw/sw: alusrca=1, alusrcb=10, sext=1, aluc=add -> MEM.
REQ-023 EXE, beq/bne: alusrca=1, alusrcb=00, aluc=sub, pcsource=01; wpc=z for beq, wpc=~z for bne -> IF.
REQ-024 MEM: iord=1; sw asserts wmem=1 each cycle until mem_ready=1, then -> IF; lw waits for mem_ready=1, then -> WB.
REQ-025 WB: wreg=1; regrt=1 for I-type and lw; m2reg=1 for lw -> IF.
REQ-026 Cycle counts SHALL be: j/jal/jr 2, beq/bne 3, ALU 4, sw 4, lw 5, each with zero-wait memory; every wait cycle adds one.
REQ-027 mem_ready outside IF/MEM SHALL be ignored.

Reset
REQ-028 On rst=1 at a clock edge, state SHALL become IF, from any state including mid-MEM wait.
REQ-029 While rst=1, wpc, wir, wmem, wreg and illegal SHALL be forced to 0 regardless of state.
REQ-030 In the first cycle after rst deasserts, state=IF and outputs SHALL follow REQ-016.

Structure
REQ-031 A shared package SHALL hold state encodings, opcode/function constants, aluc codes, and alusrcb/pcsource select codes.
REQ-032 The design SHALL be split into a combinational instruction decoder sub-module (cpu_decode) that produces one-hot instruction flags, and the FSM/output logic.

Verification
REQ-033 Reset mid-MEM: sw in MEM with mem_ready=0, assert rst -> next state=IF, wmem=0 during rst.
REQ-034 add (op=000000, fun=100000), mem_ready=1 -> states IF,ID,EXE,WB; wreg=1 only in WB, regrt=0, aluc=0000.
REQ-035 lw (op=100011) with mem_ready low 2 cycles in MEM -> 7 cycles total; iord=1 in MEM; m2reg=wreg=regrt=1 in WB.
REQ-036 beq (op=000100) with z=1 -> wpc=1 and pcsource=01 in EXE; with z=0 -> wpc=0; return to IF after 3 cycles.
REQ-037 jal (op=000011) -> ID asserts wpc, wreg, jal=1, pcsource=11; next state IF.
REQ-038 op=111111 -> illegal=1 for one cycle in ID, no write enables, next state IF.
